// File: rtl/truth_table_seq_if.sv
// truth_table_seq_if: control, network and result signals of the truth-table scanner
interface truth_table_seq_if;
   logic        start;
   logic        abort;
   logic        z_in;
   logic [15:0] exp_table;
   logic [3:0]  x_out;
   logic        busy;
   logic        done;
   logic [15:0] table_out;
   logic [4:0]  ones_cnt;
   logic        table_valid;
   logic        match;
   modport master (output start, abort, z_in, exp_table,
                   input  x_out, busy, done, table_out, ones_cnt, table_valid, match);
   modport slave  (input  start, abort, z_in, exp_table,
                   output x_out, busy, done, table_out, ones_cnt, table_valid, match);
endinterface

// File: rtl/truth_table_seq.sv
// truth_table_seq: steps a 4-input network through all 16 vectors, captures z per vector
// and compares the captured table against an expected one
module truth_table_seq #(
   parameter int SETTLE = 2
) (
   input logic clk,
   input logic rst,
   truth_table_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_cnt;
   logic [3:0]  r_x;
   logic        r_done;
   logic        r_valid;
   logic        r_match;
   logic [15:0] r_table;
   logic [4:0]  r_ones;
   logic [15:0] w_table;
   // final table including the last vector, so done, valid and match rise together
   assign w_table = {bus.z_in, r_table[14:0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_x     <= '0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_match <= 1'b0;
         r_table <= '0;
         r_ones  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start && !bus.abort) begin
               r_state <= WAIT;
               r_idx   <= '0;
               r_cnt   <= '0;
               r_x     <= '0;
               r_table <= '0;
               r_ones  <= '0;
               r_valid <= 1'b0;
               r_match <= 1'b0;
            end
            WAIT: if (bus.abort) begin
               r_state <= IDLE;
               r_x     <= '0;
            end else begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(SETTLE - 1)) r_state <= SAMPLE;
            end
            SAMPLE: if (bus.abort) begin
               r_state <= IDLE;
               r_x     <= '0;
            end else begin
               r_table[r_idx] <= bus.z_in;
               r_ones         <= r_ones + {4'd0, bus.z_in};
               if (r_idx == 4'd15) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_valid <= 1'b1;
                  r_match <= (w_table == bus.exp_table);
               end else begin
                  r_idx   <= r_idx + 4'd1;
                  r_x     <= r_idx + 4'd1;
                  r_cnt   <= '0;
                  r_state <= WAIT;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_x     <= '0;
               r_match <= (r_table == bus.exp_table);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.x_out       = r_x;
   assign bus.busy        = (r_state != IDLE);
   assign bus.done        = r_done;
   assign bus.table_out   = r_table;
   assign bus.ones_cnt    = r_ones;
   assign bus.table_valid = r_valid;
   assign bus.match       = r_match;
endmodule

// File: tb/tb_truth_table_seq.sv
// tb_truth_table_seq: directed scans with a done-triggered scoreboard on two instances
module tb_truth_table_seq;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   cs = 0;
   int   bad;
   logic glitch_en = 1'b0;
   typedef struct {int c; logic [15:0] t; logic [4:0] o; logic m;} exp_t;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   truth_table_seq_if i1();
   truth_table_seq_if i2();
   truth_table_seq #(.SETTLE(2)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
   truth_table_seq #(.SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // network z = x2&x4&((x1&x2)|(x3&x4)), toggled outside SAMPLE cycles when glitching
   assign i1.z_in = (i1.x_out[1] & i1.x_out[3] & ((i1.x_out[0] & i1.x_out[1]) | (i1.x_out[2] & i1.x_out[3])))
                    ^ (glitch_en && ((cyc - cs + 1) % 3 != 0));
   assign i2.z_in = 1'b1;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic go(input int n);
      while (cyc != n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic start1(input logic [15:0] ex, input logic push);
      i1.exp_table = ex;
      i1.start = 1'b1;
      @(posedge clk);
      #1;
      cs = cyc;
      i1.start = 1'b0;
      if (push) q1.push_back('{cs + 48, 16'hC800, 5'd3, (ex == 16'hC800)});
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) if (i1.done) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
         e1 = q1.pop_front();
         chk("done1_cycle", cyc, e1.c);
         chk("table1", i1.table_out, e1.t);
         chk("ones1", i1.ones_cnt, e1.o);
         chk("match1", i1.match, e1.m);
         chk("valid1", i1.table_valid, 1);
      end
   end
   always @(negedge clk) if (i2.done) begin
      if (q2.size() == 0) chk("done2_unexpected", 1, 0);
      else begin
         e2 = q2.pop_front();
         chk("done2_cycle", cyc, e2.c);
         chk("table2", i2.table_out, e2.t);
         chk("ones2", i2.ones_cnt, e2.o);
         chk("match2", i2.match, e2.m);
         chk("valid2", i2.table_valid, 1);
      end
   end
   initial begin
      rst = 1'b1;
      i1.start = 1'b0; i1.abort = 1'b0; i1.exp_table = 16'h0;
      i2.start = 1'b0; i2.abort = 1'b0; i2.exp_table = 16'hFFFF;
      repeat (3) @(negedge clk);
      chk("reset_state", {i1.x_out, i1.busy, i1.done, i1.table_out, i1.ones_cnt, i1.table_valid, i1.match}, 0);
      i1.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      i1.start = 1'b0;
      step;
      chk("start_in_rst_ignored", i1.busy, 0);
      // nominal scan with WAIT glitches and a stray start while busy
      glitch_en = 1'b1;
      start1(16'hC800, 1'b1);
      chk("busy_after_start", i1.busy, 1);
      go(cs + 4);
      i1.start = 1'b1;
      step;
      i1.start = 1'b0;
      go(cs + 50);
      glitch_en = 1'b0;
      chk("idle_busy_low", i1.busy, 0);
      chk("idle_valid_held", i1.table_valid, 1);
      chk("idle_x_zero", i1.x_out, 0);
      // mismatching expectation, abort during DONE must not cancel completion
      start1(16'hC801, 1'b1);
      go(cs + 48);
      i1.abort = 1'b1;
      step;
      i1.abort = 1'b0;
      chk("abort_done_valid", i1.table_valid, 1);
      chk("abort_done_match", i1.match, 0);
      step;
      // abort in cycle 10
      start1(16'hC800, 1'b0);
      go(cs + 9);
      i1.abort = 1'b1;
      step;
      i1.abort = 1'b0;
      chk("abort_busy", i1.busy, 0);
      chk("abort_x", i1.x_out, 0);
      chk("abort_valid", i1.table_valid, 0);
      repeat (45) step;
      start1(16'hC800, 1'b1);
      go(cs + 52);
      // abort beats start in IDLE
      i1.start = 1'b1;
      i1.abort = 1'b1;
      step;
      i1.start = 1'b0;
      i1.abort = 1'b0;
      chk("abort_wins_start", i1.busy, 0);
      // reset in cycle 20
      start1(16'hC800, 1'b0);
      go(cs + 19);
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("mid_reset", {i1.x_out, i1.busy, i1.done, i1.table_out, i1.ones_cnt, i1.table_valid, i1.match}, 0);
      repeat (40) step;
      // SETTLE=1, z tied high: x_out walks 0..15 two cycles each
      i2.start = 1'b1;
      step;
      cs = cyc;
      i2.start = 1'b0;
      q2.push_back('{cs + 32, 16'hFFFF, 5'd16, 1'b1});
      bad = 0;
      for (int m = 1; m <= 33; m++) begin
         if (i2.x_out !== ((m < 33) ? 4'((m - 1) / 2) : 4'd15)) bad++;
         step;
      end
      chk("x_walk_errors", bad, 0);
      repeat (4) step;
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/truth_table_seq.md
TRUTH_TABLE_SEQ -- requirements
Module: truth_table_seq

Interface
REQ-001 SHALL provide parameter SETTLE, default 2: cycles each input vector is held before z_in is sampled; legal range 1..15.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit: request a full 16-vector scan.
REQ-005 SHALL provide port abort, input, 1 bit: cancel the scan in progress.
REQ-006 SHALL provide port z_in, input, 1 bit: output of the 4-input logic network under control.
REQ-007 SHALL provide port exp_table, input, 16 bits: expected truth table, bit i = expected z for vector i.
REQ-008 SHALL provide port x_out, output, 4 bits: drives the network inputs; x1=x_out[0], x2=x_out[1], x3=x_out[2], x4=x_out[3].
REQ-009 SHALL provide port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL provide port done, output, 1 bit: one-cycle pulse at scan completion.
REQ-011 SHALL provide port table_out, output, 16 bits: captured truth table, bit i = z_in sampled for vector i.
REQ-012 SHALL provide port ones_cnt, output, 5 bits: number of vectors for which z_in sampled 1 (0..16).
REQ-013 SHALL provide port table_valid, output, 1 bit: table_out, ones_cnt and match hold a completed scan.
REQ-014 SHALL provide port match, output, 1 bit: table_out == exp_table; qualified by table_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SAMPLE, DONE; the unused encoding SHALL recover to IDLE.
REQ-016 IDLE, start=1: next state WAIT; vector index=0; x_out=0; settle counter=0; table_out=0; ones_cnt=0; table_valid=0; match=0.
REQ-017 IDLE, start=0: hold all outputs, including a previous table_valid/table_out result.
REQ-018 WAIT: settle counter increments each cycle; when counter==SETTLE-1, next state SAMPLE; x_out held constant throughout.
REQ-019 SAMPLE: table_out[index] <= z_in; ones_cnt <= ones_cnt + z_in.
REQ-020 SAMPLE, index<15: index++, x_out=index+1, counter=0, next state WAIT.
REQ-021 SAMPLE, index==15: next state DONE; x_out holds 15.
REQ-022 DONE: done=1 for exactly this cycle; table_valid=1; match=(table_out==exp_table), with exp_table sampled in DONE; x_out=0; next state IDLE.
REQ-023 Latency: start accepted at cycle 0; each vector occupies SETTLE+1 cycles; final SAMPLE at cycle 16*(SETTLE+1); done high at cycle 16*(SETTLE+1)+1 (49 for SETTLE=2).
REQ-024 start while busy=1 SHALL be ignored, with no restart and no effect on index.
REQ-025 abort=1 in WAIT or SAMPLE SHALL, next cycle: go to IDLE, set x_out=0, keep table_valid=0, produce no done pulse; partial table_out is don't-care.
REQ-026 abort and start asserted together in IDLE: abort SHALL win and the scan SHALL not start.
REQ-027 abort in DONE SHALL be ignored; the completion SHALL stand.
REQ-028 ones_cnt SHALL reach 16 without wrap (5-bit width).
REQ-029 z_in SHALL be sampled only in SAMPLE; glitches in WAIT SHALL have no effect.

Reset
REQ-030 rst=1 at a clock edge SHALL force, regardless of state: IDLE, index=0, counter=0, x_out=0, busy=0, done=0, table_out=0, ones_cnt=0, table_valid=0, match=0.
REQ-031 rst SHALL override start and abort in the same cycle.
REQ-032 A start pulse coincident with the cycle rst deasserts SHALL not be accepted; start is honoured from the first cycle after rst is low.

Verification
REQ-033 Connect z_in = x2 & x4 & ((x1&x2)|(x3&x4)), SETTLE=2, exp_table=16'hC800, pulse start -> done at cycle 49, table_out=16'hC800, ones_cnt=3, match=1, table_valid=1.
REQ-034 Same stimulus with exp_table=16'hC801 -> table_out=16'hC800, match=0, table_valid=1.
REQ-035 z_in tied 1, SETTLE=1 -> done at cycle 33, table_out=16'hFFFF, ones_cnt=16; x_out steps 0..15, each value held 2 cycles.
REQ-036 abort at cycle 10 of a scan -> busy=0 at cycle 11, x_out=0, no done pulse, table_valid=0; a new start then gives a full correct scan.
REQ-037 rst asserted mid-scan (cycle 20) -> all outputs at reset values the next cycle; a start pulse during busy (cycle 5) does not alter the done time.
